// File: rtl/dma_axi_wr_burst_master.sv
// dma_axi_wr_burst_master
//   Drains a write-data sync FIFO into an AXI4 write master port. One DMA
//   write command (start address + beat count) is split into INCR bursts.
//   Each burst is capped by MAX_BURST, by the remaining beats and by the next
//   4KB boundary. An AW is only issued once the whole burst sits in the FIFO
//   and fewer than MAX_OUTST bursts are still waiting for their B response.
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_*                 command request (valid/ready, byte address, beats)
//   fifo_*                FIFO read side (valid/ready/data) and occupancy
//   m_axi_aw*/w*/b*       AXI4 write address, write data, write response
//   done_valid/done_err   completion pulse and sticky SLVERR/DECERR flag
module dma_axi_wr_burst_master #(
  parameter int DWIDTH      = 64,
  parameter int ADDR_W      = 32,
  parameter int FIFO_AWIDTH = 10,
  parameter int BEATS_W     = 16,
  parameter int MAX_BURST   = 16,
  parameter int MAX_OUTST   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [BEATS_W-1:0]    cmd_beats,
  input  logic                  fifo_rvalid,
  output logic                  fifo_rready,
  input  logic [DWIDTH-1:0]     fifo_rdata,
  input  logic [FIFO_AWIDTH:0]  fifo_count,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  output logic [DWIDTH-1:0]     m_axi_wdata,
  output logic [DWIDTH/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wlast,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  input  logic [1:0]            m_axi_bresp,
  output logic                  done_valid,
  output logic                  done_err
);

  localparam int SZ  = $clog2(DWIDTH / 8);
  localparam int BLW = 9;                          // holds a burst length up to 256
  localparam int OW  = $clog2(MAX_OUTST + 1);
  localparam int CW  = (BEATS_W > 13) ? BEATS_W : 13;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((1 << SZ) - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CALC  = 3'd1,
    S_AW    = 3'd2,
    S_W     = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BEATS_W-1:0] remaining_q, remaining_d;
  logic [BLW-1:0]     blen_q, blen_d;
  logic [BLW-1:0]     beat_q, beat_d;
  logic [OW-1:0]      outst_q, outst_d;
  logic               awvalid_q, awvalid_d;
  logic [ADDR_W-1:0]  awaddr_q, awaddr_d;
  logic [7:0]         awlen_q, awlen_d;
  logic               err_q, err_d;
  logic               done_valid_q, done_valid_d;
  logic               done_err_q, done_err_d;

  logic               accept_s, aw_hs_s, w_hs_s, b_hs_s, can_issue_s;
  logic [12:0]        addr_lo_s, bnd_s;
  logic [CW-1:0]      min1_s, min2_s;
  logic [BLW-1:0]     blen_calc_s;
  logic               bresp_unused;

  // Only bresp[1] (SLVERR/DECERR) matters; OKAY vs EXOKAY is irrelevant here.
  assign bresp_unused  = m_axi_bresp[0];

  assign m_axi_awsize  = 3'(SZ);
  assign m_axi_awburst = 2'b01;
  assign m_axi_wstrb   = {(DWIDTH/8){1'b1}};
  assign m_axi_bready  = 1'b1;
  assign m_axi_wdata   = fifo_rdata;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awlen   = awlen_q;
  assign done_valid    = done_valid_q;
  assign done_err      = done_err_q;

  assign accept_s = cmd_valid && cmd_ready;
  assign aw_hs_s  = awvalid_q && m_axi_awready;
  assign w_hs_s   = m_axi_wvalid && m_axi_wready;
  assign b_hs_s   = m_axi_bvalid;

  // Burst length: min(remaining, MAX_BURST, beats left before the 4KB page ends).
  always_comb begin
    addr_lo_s   = {1'b0, addr_q[11:0]};
    bnd_s       = (13'd4096 - addr_lo_s) >> SZ;
    min1_s      = (CW'(remaining_q) < CW'(MAX_BURST)) ? CW'(remaining_q) : CW'(MAX_BURST);
    min2_s      = (min1_s < CW'(bnd_s)) ? min1_s : CW'(bnd_s);
    blen_calc_s = BLW'(min2_s);
    can_issue_s = (32'(fifo_count) >= 32'(blen_calc_s)) && (outst_q < OW'(MAX_OUTST));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s && (cmd_beats != {BEATS_W{1'b0}})) state_d = S_CALC;
        else                                            state_d = S_IDLE;
      end
      S_CALC: begin
        if (can_issue_s) state_d = S_AW;
        else             state_d = S_CALC;
      end
      S_AW: begin
        if (aw_hs_s) state_d = S_W;
        else         state_d = S_AW;
      end
      S_W: begin
        if (w_hs_s && m_axi_wlast) begin
          if (remaining_q != {BEATS_W{1'b0}}) state_d = S_CALC;
          else                                state_d = S_DRAIN;
        end else begin
          state_d = S_W;
        end
      end
      S_DRAIN: begin
        if (outst_q == {OW{1'b0}}) state_d = S_IDLE;
        else                       state_d = S_DRAIN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode; the W path is a zero-latency pass-through from the FIFO.
  always_comb begin
    cmd_ready    = (state_q == S_IDLE) && rst_n;
    m_axi_wvalid = (state_q == S_W) && fifo_rvalid;
    fifo_rready  = (state_q == S_W) && m_axi_wready;
    m_axi_wlast  = (state_q == S_W) && (beat_q == (blen_q - 9'd1));
  end

  // Datapath next values: address/remaining bookkeeping, AW request, counters.
  always_comb begin
    addr_d       = addr_q;
    remaining_d  = remaining_q;
    blen_d       = blen_q;
    beat_d       = beat_q;
    awvalid_d    = awvalid_q;
    awaddr_d     = awaddr_q;
    awlen_d      = awlen_q;
    err_d        = err_q;
    done_valid_d = 1'b0;
    done_err_d   = 1'b0;

    if (accept_s) begin
      addr_d       = cmd_addr & ALIGN_MASK;
      remaining_d  = cmd_beats;
      err_d        = 1'b0;
      done_valid_d = (cmd_beats == {BEATS_W{1'b0}});
    end else if (aw_hs_s) begin
      addr_d      = addr_q + (ADDR_W'(blen_q) << SZ);
      remaining_d = remaining_q - BEATS_W'(blen_q);
    end else begin
      addr_d      = addr_q;
      remaining_d = remaining_q;
    end

    if ((state_q == S_CALC) && can_issue_s) begin
      blen_d    = blen_calc_s;
      awvalid_d = 1'b1;
      awaddr_d  = addr_q;
      awlen_d   = 8'(blen_calc_s - 9'd1);
    end else if (aw_hs_s) begin
      awvalid_d = 1'b0;
    end else begin
      awvalid_d = awvalid_q;
    end

    if (state_q == S_AW) beat_d = 9'd0;
    else if (w_hs_s)     beat_d = beat_q + 9'd1;
    else                 beat_d = beat_q;

    // Error is sticky for the whole command; a later OKAY never clears it.
    if (b_hs_s && m_axi_bresp[1]) err_d = 1'b1;
    else                          err_d = err_d;

    if ((state_q == S_DRAIN) && (outst_q == {OW{1'b0}})) begin
      done_valid_d = 1'b1;
      done_err_d   = err_q;
    end else begin
      done_err_d   = 1'b0;
    end
  end

  // Outstanding-burst counter: simultaneous AW and B cancel out.
  always_comb begin
    case ({aw_hs_s, b_hs_s})
      2'b10:   outst_d = outst_q + OW'(1);
      2'b01:   outst_d = outst_q - OW'(1);
      default: outst_d = outst_q;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= {ADDR_W{1'b0}};
      remaining_q  <= {BEATS_W{1'b0}};
      blen_q       <= 9'd0;
      beat_q       <= 9'd0;
      outst_q      <= {OW{1'b0}};
      awvalid_q    <= 1'b0;
      awaddr_q     <= {ADDR_W{1'b0}};
      awlen_q      <= 8'd0;
      err_q        <= 1'b0;
      done_valid_q <= 1'b0;
      done_err_q   <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      remaining_q  <= remaining_d;
      blen_q       <= blen_d;
      beat_q       <= beat_d;
      outst_q      <= outst_d;
      awvalid_q    <= awvalid_d;
      awaddr_q     <= awaddr_d;
      awlen_q      <= awlen_d;
      err_q        <= err_d;
      done_valid_q <= done_valid_d;
      done_err_q   <= done_err_d;
    end
  end

endmodule

// File: tb/tb_dma_axi_wr_burst_master.sv
// Scoreboard bench for dma_axi_wr_burst_master: a FIFO model and an AXI slave
// model drive the DUT; expected AW bursts, W beats and completions are queued
// when a command is issued and compared as the DUT produces them.
module tb_dma_axi_wr_burst_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_beats;
  logic        fifo_rvalid, fifo_rready;
  logic [63:0] fifo_rdata;
  logic [10:0] fifo_count;
  logic        m_axi_awvalid, m_axi_awready;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_wvalid, m_axi_wready, m_axi_wlast;
  logic [63:0] m_axi_wdata;
  logic [7:0]  m_axi_wstrb;
  logic        m_axi_bvalid, m_axi_bready;
  logic [1:0]  m_axi_bresp;
  logic        done_valid, done_err;

  dma_axi_wr_burst_master dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
    .fifo_rvalid(fifo_rvalid), .fifo_rready(fifo_rready), .fifo_rdata(fifo_rdata),
    .fifo_count(fifo_count),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
    .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
    .done_valid(done_valid), .done_err(done_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] fq[$];          // FIFO contents
  logic [31:0] exp_aw_addr[$];
  logic [7:0]  exp_aw_len[$];
  logic [63:0] exp_wd[$];
  bit          exp_wl[$];
  bit          exp_done[$];
  int          bdue[$];
  logic [1:0]  bres[$];

  int cyc = 0, aw_cnt = 0, wl_cnt = 0, done_cnt = 0, done_target = 0;
  int outst_tb = 0, peak = 0, aw_beats = 0, w_beats = 0;
  int err_wl_idx = -1, bdelay = 20;
  bit stall_en = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bus models: drive at negedge, observe handshakes 1 time unit before posedge.
  initial begin : bus
    logic [63:0] d;
    bit          l;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; fifo_rvalid = 1'b0;
    fifo_rdata = 64'd0; fifo_count = 11'd0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; fifo_rvalid = 1'b0;
        m_axi_bvalid = 1'b0; fifo_count = 11'd0;
        bdue.delete(); bres.delete();
        outst_tb = 0; aw_beats = 0; w_beats = 0;
      end else begin
        m_axi_awready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        m_axi_wready  = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        fifo_rvalid   = (fq.size() > 0) && (!stall_en || ($urandom_range(0, 3) != 0));
        fifo_rdata    = (fq.size() > 0) ? fq[0] : 64'd0;
        fifo_count    = 11'(fq.size());
        m_axi_bvalid  = (bdue.size() > 0) && (bdue[0] <= cyc);
        m_axi_bresp   = m_axi_bvalid ? bres[0] : 2'b00;
      end
      #4;
      if (rst_n) begin
        if (m_axi_awvalid && m_axi_awready) begin
          outst_tb++;
          if (outst_tb > peak) peak = outst_tb;
          check_val("aw_outst_le_max", outst_tb <= 4, 1);
          aw_cnt++;
          if (exp_aw_addr.size() == 0) begin
            check_val("aw_unexpected", 1, 0);
          end else begin
            check_val("aw_addr", m_axi_awaddr, exp_aw_addr.pop_front());
            check_val("aw_len", m_axi_awlen, exp_aw_len.pop_front());
          end
          check_val("aw_size", m_axi_awsize, 3);
          check_val("aw_burst", m_axi_awburst, 1);
          aw_beats += int'(m_axi_awlen) + 1;
        end
        if (m_axi_wvalid && m_axi_wready) begin
          check_val("w_after_aw", w_beats < aw_beats, 1);
          w_beats++;
          if (exp_wd.size() == 0 || exp_wl.size() == 0) begin
            check_val("w_unexpected", 1, 0);
          end else begin
            d = exp_wd.pop_front();
            l = exp_wl.pop_front();
            check_val("w_data", m_axi_wdata, d);
            check_val("w_last", m_axi_wlast, l);
          end
          check_val("w_strb", m_axi_wstrb, 8'hFF);
          if (m_axi_wlast) begin
            bdue.push_back(cyc + bdelay);
            bres.push_back((wl_cnt == err_wl_idx) ? 2'b10 : 2'b00);
            wl_cnt++;
          end
        end
        if (fifo_rvalid && fifo_rready) begin
          check_val("pop_only_with_w", m_axi_wvalid && m_axi_wready, 1);
          if (fq.size() > 0) void'(fq.pop_front());
        end
        if (m_axi_bvalid) begin
          check_val("b_ready", m_axi_bready, 1);
          void'(bdue.pop_front());
          void'(bres.pop_front());
          outst_tb--;
        end
        if (done_valid) begin
          check_val("done_outst_zero", outst_tb, 0);
          if (exp_done.size() == 0) check_val("done_unexpected", 1, 0);
          else                      check_val("done_err", done_err, exp_done.pop_front());
          done_cnt++;
        end
      end
    end
  end

  task automatic push_data(input int n);
    logic [63:0] d;
    for (int i = 0; i < n; i++) begin
      d = {$urandom, $urandom};
      fq.push_back(d);
      exp_wd.push_back(d);
    end
  endtask

  task automatic send_cmd(input logic [31:0] a, input int beats);
    int n = 0;
    bit acc = 1'b0;
    cmd_addr = a; cmd_beats = 16'(beats); cmd_valid = 1'b1;
    while (!acc && n < 200) begin
      #4;
      acc = cmd_ready;
      @(negedge clk);
      n++;
    end
    cmd_valid = 1'b0;
    if (!acc) check_val("cmd_accept", 0, 1);
  endtask

  // Independent split model: min(remaining, 16, beats to the 4KB page end).
  task automatic run_cmd(input logic [31:0] a, input int beats, input int err_burst);
    logic [31:0] ad;
    int rem, b, bnd, nb;
    ad = a & 32'hFFFF_FFF8; rem = beats; nb = 0;
    while (rem > 0) begin
      bnd = (4096 - int'(ad[11:0])) / 8;
      b = rem;
      if (b > 16)  b = 16;
      if (b > bnd) b = bnd;
      exp_aw_addr.push_back(ad);
      exp_aw_len.push_back(8'(b - 1));
      for (int i = 0; i < b; i++) exp_wl.push_back(i == b - 1);
      ad = ad + 32'(b * 8);
      rem -= b;
      nb++;
    end
    err_wl_idx = (err_burst >= 0) ? wl_cnt + err_burst : -1;
    exp_done.push_back((err_burst >= 0) && (err_burst < nb));
    done_target++;
    send_cmd(a, beats);
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_cnt < done_target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_val("done_seen", done_cnt >= done_target, 1);
    check_val("aw_all_issued", exp_aw_addr.size(), 0);
    check_val("w_all_written", exp_wd.size(), 0);
  endtask

  initial begin : main
    int aw0, n;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = 32'd0; cmd_beats = 16'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("rst_cmd_ready", cmd_ready, 1);
    check_val("rst_awvalid", m_axi_awvalid, 0);
    check_val("rst_wvalid", m_axi_wvalid, 0);
    check_val("rst_fifo_rready", fifo_rready, 0);
    check_val("rst_done_valid", done_valid, 0);
    check_val("rst_done_err", done_err, 0);
    @(negedge clk);

    // 40 beats from 0x1000: bursts 16/16/8
    push_data(40);
    run_cmd(32'h0000_1000, 40, -1);
    wait_done();

    // 4KB split: 4 beats at 0x0FE0 then 6 at 0x1000
    push_data(10);
    run_cmd(32'h0000_0FE0, 10, -1);
    wait_done();

    // Burst must wait until all 16 beats are buffered
    aw0 = aw_cnt;
    push_data(3);
    run_cmd(32'h0000_3000, 16, -1);
    repeat (20) @(negedge clk);
    check_val("aw_wait_fifo", aw_cnt - aw0, 0);
    stall_en = 1'b1;
    push_data(13);
    wait_done();
    push_data(37);
    run_cmd(32'h0000_3F90, 37, -1);
    wait_done();
    stall_en = 1'b0;

    // Slow B responses: outstanding window fills up to 4
    bdelay = 80; peak = 0;
    push_data(96);
    run_cmd(32'h0000_8000, 96, -1);
    wait_done();
    check_val("outst_peak", peak, 4);
    bdelay = 20;

    // SLVERR on burst 2 of 3, then a clean command
    push_data(40);
    run_cmd(32'h0000_9000, 40, 1);
    wait_done();
    push_data(8);
    run_cmd(32'h0000_A000, 8, -1);
    wait_done();

    // Zero-beat command completes on the next cycle without bus traffic
    aw0 = aw_cnt;
    run_cmd(32'h0000_B000, 0, -1);
    #1;
    check_val("zero_done_next", done_valid, 1);
    check_val("zero_done_err", done_err, 0);
    @(negedge clk);
    wait_done();
    repeat (5) @(negedge clk);
    check_val("zero_no_aw", aw_cnt - aw0, 0);

    // Reset in the middle of a W burst
    push_data(32);
    run_cmd(32'h0000_C000, 32, -1);
    n = 0;
    while (w_beats < 3 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_val("reach_w", w_beats >= 3, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_awvalid", m_axi_awvalid, 0);
    check_val("mid_rst_wvalid", m_axi_wvalid, 0);
    check_val("mid_rst_fifo_rready", fifo_rready, 0);
    check_val("mid_rst_done", done_valid, 0);
    fq.delete(); exp_wd.delete(); exp_wl.delete();
    exp_aw_addr.delete(); exp_aw_len.delete(); exp_done.delete();
    done_target = done_cnt;
    err_wl_idx = -1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("post_rst_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    push_data(5);
    run_cmd(32'h0000_D000, 5, -1);
    wait_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
